// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 2-read/1-write register file with write-to-read bypass and a hardwired zero entry
module reg_file_2r1w #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b
);
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] we;
    logic                wr_ok;
    logic                a_zero, b_zero;
    assign wr_ok  = wr_en && !reset && 32'(wr_addr) != ZERO_REG && 32'(wr_addr) < NUM_REGS;
    assign a_zero = 32'(rd_addr_a) == ZERO_REG || 32'(rd_addr_a) >= NUM_REGS;
    assign b_zero = 32'(rd_addr_b) == ZERO_REG || 32'(rd_addr_b) >= NUM_REGS;
    genvar r;
    for (r = 0; r < NUM_REGS; r++) begin : g_dec
        assign we[r] = wr_ok && 32'(wr_addr) == r;
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reset)
                regs[i] <= '0;
            else if (we[i])
                regs[i] <= wr_data;
        end
    end
    // wr_ok already excludes the zero entry and reset, so bypass needs only an address match
    assign rd_data_a = a_zero ? '0 : (wr_ok && rd_addr_a == wr_addr) ? wr_data : regs[rd_addr_a];
    assign rd_data_b = b_zero ? '0 : (wr_ok && rd_addr_b == wr_addr) ? wr_data : regs[rd_addr_b];
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed stimulus queues expected read data; a negedge monitor pops and compares
module tb_reg_file_2r1w;
    logic        clk = 0;
    logic        reset = 1;
    logic        wr_en = 0;
    logic [4:0]  wr_addr = 0;
    logic [63:0] wr_data = 0;
    logic [4:0]  rd_addr_a = 0;
    logic [63:0] rd_data_a;
    logic [4:0]  rd_addr_b = 0;
    logic [63:0] rd_data_b;

    typedef struct {
        string       name;
        bit          ca;
        logic [63:0] ea;
        bit          cb;
        logic [63:0] eb;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_file_2r1w dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b)
    );

    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            if (e.ca) begin
                checks++;
                if (rd_data_a !== e.ea) begin
                    errors++;
                    $display("FAIL %s port A addr=%0d got=%h want=%h", e.name, rd_addr_a, rd_data_a, e.ea);
                end
            end
            if (e.cb) begin
                checks++;
                if (rd_data_b !== e.eb) begin
                    errors++;
                    $display("FAIL %s port B addr=%0d got=%h want=%h", e.name, rd_addr_b, rd_data_b, e.eb);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic we, input logic [4:0] wa, input logic [63:0] wd,
                        input logic [4:0] ra, input logic [4:0] rb,
                        input bit ca, input logic [63:0] ea, input bit cb, input logic [63:0] eb,
                        input string name);
        exp_t x;
        @(posedge clk);
        #1;
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
        x.name = name; x.ca = ca; x.ea = ea; x.cb = cb; x.eb = eb;
        if (ca || cb) q.push_back(x);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
        for (int i = 0; i < 32; i++)
            step(0, 0, 0, 0, 5'(i), 5'(31 - i), 1, 0, 1, 0, "post_reset");
        step(0, 1, 5, 64'hDEAD_BEEF_0123_4567, 4, 6, 1, 0, 1, 0, "wr5_neighbours");
        step(0, 0, 0, 0, 5, 5, 1, 64'hDEAD_BEEF_0123_4567, 1, 64'hDEAD_BEEF_0123_4567, "rd5");
        step(0, 0, 0, 0, 4, 6, 1, 0, 1, 0, "rd4_6");
        step(0, 1, 7, 64'h1234, 7, 5, 1, 64'h1234, 1, 64'hDEAD_BEEF_0123_4567, "bypass7");
        step(0, 0, 0, 0, 7, 7, 1, 64'h1234, 1, 64'h1234, "held7");
        step(0, 1, 31, '1, 31, 31, 1, 0, 1, 0, "wr_xzr_same");
        step(0, 0, 0, 0, 31, 7, 1, 0, 1, 64'h1234, "wr_xzr_next");
        for (int i = 0; i < 31; i++)
            step(0, 1, 5'(i), 64'd1 << i, 5'(i), 5'(i), 1, 64'd1 << i, 1, 64'd1 << i, "walk_bypass");
        for (int i = 0; i < 32; i++)
            step(0, 0, 0, 0, 5'(i), 5'(31 - i), 1, i < 31 ? 64'd1 << i : 64'd0,
                 1, i > 0 ? 64'd1 << (31 - i) : 64'd0, "walk_read");
        step(0, 1, 3, 64'hAA, 0, 0, 1, 64'h1, 0, 0, "wr3");
        step(1, 1, 3, 64'h55, 3, 5, 1, 64'hAA, 1, 64'h20, "reset_vs_write");
        step(0, 0, 0, 0, 3, 5, 1, 0, 1, 0, "after_reset");
        step(0, 0, 9, 64'hFF, 9, 9, 1, 0, 1, 0, "no_we_bypass");
        step(0, 0, 0, 0, 9, 30, 1, 0, 1, 0, "no_we_hold");
        for (int n = 0; n < 5 && q.size() != 0; n++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
